// File: rtl/cp0_if.sv
// Pipeline-to-CP0 bundle: mfc0/mtc0 access, M-stage exception info, interrupts, eret.
// No handshake; all signals are level, sampled every cycle.
// No backpressure.
interface cp0_if;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] M_PC;
    logic [4:0]  M_ExcCode;
    logic        M_BD;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        Req;
    logic [31:0] EPCOut;
    logic [31:0] DOut;

    modport master (
        output A1, A2, DIn, WE, M_PC, M_ExcCode, M_BD, HWInt, EXLClr,
        input  Req, EPCOut, DOut
    );

    modport slave (
        input  A1, A2, DIn, WE, M_PC, M_ExcCode, M_BD, HWInt, EXLClr,
        output Req, EPCOut, DOut
    );
endinterface

// File: rtl/cp0.sv
// Coprocessor 0: SR/Cause/EPC/PRID, exception and interrupt request generation.
// Req and DOut are same-cycle combinational; register updates visible one cycle after the edge.
// No backpressure; an exception or interrupt request overrides a same-cycle mtc0.
module cp0 #(
    parameter logic [31:0] PRID = 32'h0000_0707
) (
    input  logic clk,
    input  logic reset,
    cp0_if.slave bus
);

    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic        req;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    assign int_req = (|(bus.HWInt & im)) & ie & ~exl;
    assign exc_req = (bus.M_ExcCode != 5'd0) & ~exl;
    assign req     = int_req | exc_req;

    assign sr_word    = {16'd0, im, 8'd0, exl, ie};
    assign cause_word = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};

    assign bus.Req    = req;
    assign bus.EPCOut = epc;

    always_comb begin
        bus.DOut = 32'd0;
        case (bus.A1)
            5'd12:   bus.DOut = sr_word;
            5'd13:   bus.DOut = cause_word;
            5'd14:   bus.DOut = epc;
            5'd15:   bus.DOut = PRID;
            default: bus.DOut = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im       <= 6'd0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= 6'd0;
            exc_code <= 5'd0;
            epc      <= 32'd0;
        end else begin
            ip <= bus.HWInt;
            if (req) begin
                // Interrupts win over exceptions: ExcCode 0 marks an interrupt entry.
                exl      <= 1'b1;
                bd       <= bus.M_BD;
                exc_code <= int_req ? 5'd0 : bus.M_ExcCode;
                epc      <= (bus.M_BD ? bus.M_PC - 32'd4 : bus.M_PC) & 32'hFFFF_FFFC;
            end else begin
                if (bus.WE && bus.A2 == 5'd12) begin
                    im  <= bus.DIn[15:10];
                    exl <= bus.DIn[1];
                    ie  <= bus.DIn[0];
                end
                if (bus.WE && bus.A2 == 5'd14)
                    epc <= bus.DIn & 32'hFFFF_FFFC;
                // eret beats a concurrent SR write, but only for EXL.
                if (bus.EXLClr)
                    exl <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cp0.sv
// Randomized plus directed bench for cp0; expectations come from a word-level architectural model
// and are checked by a monitor that pops a scoreboard queue each cycle.
module tb_cp0;

    localparam logic [31:0] PRID = 32'h0000_0707;

    logic clk;
    logic reset;
    cp0_if bus();

    cp0 #(.PRID(PRID)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [31:0] dout;
        logic [31:0] epc;
        int          id;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;
    int step_id = 0;
    bit checking = 0;

    // Architectural state held as the 32-bit words software would see.
    logic [31:0] m_sr;
    logic [31:0] m_cause;
    logic [31:0] m_epc;

    task automatic step(input bit rst, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [31:0] din, input bit we, input logic [31:0] pc,
                        input logic [4:0] ec, input bit bdly, input logic [5:0] hw,
                        input bit clr);
        exp_t e;
        bit ireq, ereq, rq;
        @(negedge clk);
        reset         = rst;
        bus.A1        = a1;
        bus.A2        = a2;
        bus.DIn       = din;
        bus.WE        = we;
        bus.M_PC      = pc;
        bus.M_ExcCode = ec;
        bus.M_BD      = bdly;
        bus.HWInt     = hw;
        bus.EXLClr    = clr;
        step_id++;

        ireq = ((hw & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
        ereq = (ec != 5'd0) && !m_sr[1];
        rq   = ireq || ereq;

        if (checking) begin
            e.req = rq;
            e.epc = m_epc;
            e.id  = step_id;
            if (a1 == 5'd12)      e.dout = m_sr;
            else if (a1 == 5'd13) e.dout = m_cause;
            else if (a1 == 5'd14) e.dout = m_epc;
            else if (a1 == 5'd15) e.dout = PRID;
            else                  e.dout = 32'd0;
            sb.push_back(e);
        end

        if (rst) begin
            m_sr = 32'd0;
            m_cause = 32'd0;
            m_epc = 32'd0;
        end else if (rq) begin
            m_sr[1] = 1'b1;
            m_cause = ({31'd0, bdly} << 31) | ({26'd0, hw} << 10)
                    | ({27'd0, (ireq ? 5'd0 : ec)} << 2);
            m_epc = (bdly ? pc - 32'd4 : pc) & ~32'd3;
        end else begin
            m_cause = (m_cause & ~(32'h3F << 10)) | ({26'd0, hw} << 10);
            if (we && a2 == 5'd12) m_sr  = din & 32'h0000_FC03;
            if (we && a2 == 5'd14) m_epc = din & ~32'd3;
            if (clr) m_sr[1] = 1'b0;
        end
    endtask

    task automatic idle(input logic [4:0] a1, input logic [5:0] hw);
        step(0, a1, 5'd0, 32'd0, 0, 32'd0, 5'd0, 0, hw, 0);
    endtask

    // Monitor: samples mid-low-phase, well away from the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if (bus.Req !== e.req) begin
                    bad++;
                    $display("FAIL req step=%0d got=%b want=%b", e.id, bus.Req, e.req);
                end
                total++;
                if (bus.DOut !== e.dout) begin
                    bad++;
                    $display("FAIL dout step=%0d A1=%0d got=%h want=%h", e.id, bus.A1, bus.DOut, e.dout);
                end
                total++;
                if (bus.EPCOut !== e.epc) begin
                    bad++;
                    $display("FAIL epcout step=%0d got=%h want=%h", e.id, bus.EPCOut, e.epc);
                end
            end
        end
    end

    initial begin
        m_sr = 32'd0;
        m_cause = 32'd0;
        m_epc = 32'd0;
        step(1, 5'd15, 5'd0, 32'd0, 0, 32'd0, 5'd0, 0, 6'h3F, 0);
        checking = 1;

        // Reset overrides WE/EXLClr/exception; IP not captured on a reset edge.
        step(1, 5'd13, 5'd12, 32'hFFFF_FFFF, 1, 32'h100, 5'd3, 1, 6'h3F, 1);
        idle(5'd15, 6'h3F);
        idle(5'd12, 6'h3F);
        idle(5'd14, 6'h3F);
        idle(5'd13, 6'h00);

        // IM bit 0 + IE, then an interrupt at PC 0x3010.
        step(0, 5'd12, 5'd12, 32'h0000_0401, 1, 32'd0, 5'd0, 0, 6'h00, 0);
        step(0, 5'd12, 5'd0, 32'd0, 0, 32'h0000_3010, 5'd0, 0, 6'b000001, 0);
        idle(5'd12, 6'b000001);
        idle(5'd13, 6'b000001);
        idle(5'd14, 6'b000001);

        // Under EXL nothing is taken; eret re-opens the pending interrupt.
        step(0, 5'd13, 5'd0, 32'd0, 0, 32'h0000_3050, 5'd4, 0, 6'b000001, 0);
        step(0, 5'd12, 5'd0, 32'd0, 0, 32'h0000_3054, 5'd0, 0, 6'b000001, 1);
        step(0, 5'd12, 5'd0, 32'd0, 0, 32'h0000_3058, 5'd0, 0, 6'b000001, 0);
        step(0, 5'd12, 5'd0, 32'd0, 0, 32'd0, 5'd0, 0, 6'b000000, 1);

        // Exception in a delay slot.
        step(0, 5'd14, 5'd0, 32'd0, 0, 32'h0000_3024, 5'd10, 1, 6'h00, 0);
        idle(5'd14, 6'h00);
        idle(5'd13, 6'h00);
        step(0, 5'd12, 5'd0, 32'd0, 0, 32'd0, 5'd0, 0, 6'h00, 1);

        // Interrupt + exception + mtc0 EPC in one cycle.
        step(0, 5'd14, 5'd14, 32'h1234_5678, 1, 32'h0000_3040, 5'd12, 0, 6'b000001, 0);
        idle(5'd14, 6'h00);
        idle(5'd13, 6'h00);
        step(0, 5'd12, 5'd0, 32'd0, 0, 32'd0, 5'd0, 0, 6'h00, 1);

        // mtc0 EPC alignment, mtc0 Cause ignored, eret + SR write together.
        step(0, 5'd14, 5'd14, 32'h0000_3007, 1, 32'd0, 5'd0, 0, 6'h00, 0);
        idle(5'd14, 6'h00);
        step(0, 5'd13, 5'd13, 32'hFFFF_FFFF, 1, 32'd0, 5'd0, 0, 6'h00, 0);
        idle(5'd13, 6'h00);
        step(0, 5'd12, 5'd12, 32'hFFFF_FFFF, 1, 32'd0, 5'd0, 0, 6'h00, 1);
        idle(5'd12, 6'h00);
        step(0, 5'd12, 5'd15, 32'hFFFF_FFFF, 1, 32'd0, 5'd0, 0, 6'h00, 0);
        idle(5'd12, 6'h00);

        for (int i = 0; i < 3000; i++) begin
            logic [4:0]  a1, a2, ec;
            logic [31:0] din, pc;
            logic [5:0]  hw;
            bit          rst, we, bdly, clr;
            rst  = ($urandom_range(0, 199) == 0);
            a1   = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(11, 16));
            a2   = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
            din  = $urandom;
            we   = ($urandom_range(0, 3) == 0);
            pc   = $urandom;
            ec   = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'd0;
            bdly = $urandom_range(0, 1) == 1;
            hw   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            clr  = ($urandom_range(0, 5) == 0);
            step(rst, a1, a2, din, we, pc, ec, bdly, hw, clr);
        end

        repeat (3) @(negedge clk);
        #5;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cp0.md
CP0 -- requirements
Module: cp0

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter: PRID, default 32'h0000_0707, constant value returned for register 15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high; sampled on rising clk.
REQ-005 A1  input  5  read register number (mfc0).
REQ-006 A2  input  5  write register number (mtc0).
REQ-007 DIn  input  32  write data (mtc0).
REQ-008 WE  input  1  write enable for register A2.
REQ-009 M_PC  input  32  PC of the instruction in the M stage.
REQ-010 M_ExcCode  input  5  exception code of the M-stage instruction; 0 = none.
REQ-011 M_BD  input  1  M-stage instruction is in a branch delay slot.
REQ-012 HWInt  input  6  external interrupt lines, level-sensitive, active-high.
REQ-013 EXLClr  input  1  eret in M stage; clears EXL.
REQ-014 Req  output  1  take exception/interrupt this cycle (flush pipeline, redirect to handler).
REQ-015 EPCOut  output  32  current EPC, for eret target.
REQ-016 DOut  output  32  combinational read data of register A1.

Function
REQ-017 SHALL hold SR (12): IM = SR[15:10], EXL = SR[1], IE = SR[0]; other bits read 0.
REQ-018 SHALL hold Cause (13): BD = [31], IP = [15:10], ExcCode = [6:2]; other bits read 0.
REQ-019 SHALL hold EPC (14), 32 bits, bits [1:0] always 0.
REQ-020 DOut SHALL return SR/Cause/EPC/PRID for A1 = 12/13/14/15, else 0; no bypass of same-cycle writes.
REQ-021 IntReq = |(HWInt & IM) & IE & ~EXL; ExcReq = (M_ExcCode != 0) & ~EXL; Req = IntReq | ExcReq, combinational.
REQ-022 Interrupt SHALL take priority over exception when both asserted in one cycle.
REQ-023 On rising clk with Req: EXL <= 1; Cause.BD <= M_BD; Cause.ExcCode <= IntReq ? 0 : M_ExcCode; EPC <= (M_BD ? M_PC - 4 : M_PC) with bits [1:0] forced 0; subtraction modulo 2^32.
REQ-024 Cause.IP SHALL load HWInt every cycle, regardless of Req, WE or EXL.
REQ-025 WE with Req asserted: write discarded (Req wins).
REQ-026 WE without Req: A2 = 12 writes IM, EXL, IE from DIn; A2 = 14 writes EPC = {DIn[31:2], 2'b00}; A2 = 13, 15 and others ignored.
REQ-027 EXLClr without Req: EXL <= 0 next edge; EXLClr and WE to SR in same cycle: EXLClr wins for EXL only, IM/IE from DIn.
REQ-028 While EXL = 1: Req SHALL stay 0 for all HWInt and M_ExcCode (no nesting).
REQ-029 Latency: Req same-cycle; register effects visible on DOut/EPCOut the cycle after the edge.

Reset
REQ-030 On reset: SR = 0, Cause = 0, EPC = 0; Req = 0 from the next cycle; outputs combinational from cleared state.
REQ-031 Reset SHALL override Req, WE and EXLClr in the same cycle; HWInt is not captured into IP on a reset edge.

Verification
REQ-032 Reset, then read A1=15 -> DOut = PRID; A1=12/13/14 -> 0; Req = 0 with HWInt = 6'h3F.
REQ-033 mtc0 SR = 32'h0000_0401, HWInt = 6'b000001 -> Req = 1 same cycle; next cycle EXL = 1, Cause.ExcCode = 0, EPC = M_PC (e.g. 32'h0000_3010).
REQ-034 EXL = 0, M_ExcCode = 5'd10, M_BD = 1, M_PC = 32'h0000_3024 -> Req = 1; next cycle EPC = 32'h0000_3020, Cause = 32'h8000_0028 (IP = 0).
REQ-035 EXL = 1, M_ExcCode = 5'd4, HWInt enabled -> Req = 0; EXLClr pulse -> next cycle EXL = 0, Req = 1 if HWInt still pending.
REQ-036 Same cycle: interrupt pending, M_ExcCode = 5'd12, WE to EPC with DIn = 32'h1234_5678 -> Cause.ExcCode = 0, EPC = M_PC, write discarded.
REQ-037 mtc0 EPC with DIn = 32'h0000_3007 -> EPCOut = 32'h0000_3004; mtc0 to Cause -> Cause unchanged.
